// File: rtl/regfile_pkg.sv
// Shared constants for the register-file writeback path.
package regfile_pkg;

  localparam int unsigned DFLT_DATA_WIDTH = 32;
  localparam int unsigned DFLT_ADDR_WIDTH = 4;
  localparam int unsigned DFLT_NUM_REQ    = 3;

  localparam logic [3:0] REG_PC = 4'd15;

  localparam int unsigned REQ_ALU = 0;
  localparam int unsigned REQ_LSU = 1;
  localparam int unsigned REQ_MUL = 2;

endpackage

// File: rtl/wb_age_prio_arb.sv
// Fixed-priority arbiter with per-requester age counters; a requester that has
// lost STARVE_LIMIT consecutive cycles is promoted above the fixed order.
module wb_age_prio_arb #(
  parameter int unsigned NUM_REQ      = 3,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic [NUM_REQ-1:0] valid,
  output logic [NUM_REQ-1:0] grant_c
);

  localparam int unsigned AGE_W = $clog2(STARVE_LIMIT + 1);

  logic [AGE_W-1:0]   age [NUM_REQ];
  logic [NUM_REQ-1:0] starved;
  logic [NUM_REQ-1:0] cand;

  // Starved requesters form the candidate set if any exist; lowest index wins.
  always_comb begin
    grant_c = '0;
    starved = '0;
    cand    = '0;
    if (!rst && !flush) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        starved[i] = valid[i] && (age[i] == AGE_W'(STARVE_LIMIT));
      end
      cand    = (|starved) ? starved : valid;
      grant_c = cand & (~cand + NUM_REQ'(1));
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rst || flush) begin
        age[i] <= '0;
      end else if (!valid[i] || grant_c[i]) begin
        age[i] <= '0;
      end else if (age[i] != AGE_W'(STARVE_LIMIT)) begin
        age[i] <= age[i] + AGE_W'(1);
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port among writeback requesters; writes
// to R15 are steered to the PC-write output instead.
module regfile_wb_arbiter #(
  parameter int unsigned DATA_WIDTH   = regfile_pkg::DFLT_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH   = regfile_pkg::DFLT_ADDR_WIDTH,
  parameter int unsigned NUM_REQ      = regfile_pkg::DFLT_NUM_REQ,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic                          flush,
  output logic                          rf_we,
  output logic [ADDR_WIDTH-1:0]         rf_waddr,
  output logic [DATA_WIDTH-1:0]         rf_wdata,
  output logic                          pc_wr_valid,
  output logic [DATA_WIDTH-1:0]         pc_wr_data,
  output logic [1:0]                    grant_id
);

  import regfile_pkg::*;

  logic [NUM_REQ-1:0]    grant;
  logic                  hs;
  logic [1:0]            sel_id;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;

  wb_age_prio_arb #(
    .NUM_REQ      (NUM_REQ),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .valid   (req_valid),
    .grant_c (grant)
  );

  assign req_ready = grant;

  // Mux the granted requester's payload; grant is one-hot or zero.
  always_comb begin
    hs       = |grant;
    sel_id   = '0;
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_id   = 2'(i);
        sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Single output stage; address/data hold when no write lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we       <= 1'b0;
      rf_waddr    <= '0;
      rf_wdata    <= '0;
      pc_wr_valid <= 1'b0;
      pc_wr_data  <= '0;
      grant_id    <= '0;
    end else begin
      rf_we       <= 1'b0;
      pc_wr_valid <= 1'b0;
      if (hs) begin
        grant_id <= sel_id;
        if (sel_addr == ADDR_WIDTH'(REG_PC)) begin
          pc_wr_valid <= 1'b1;
          pc_wr_data  <= sel_data;
        end else begin
          rf_we    <= 1'b1;
          rf_waddr <= sel_addr;
          rf_wdata <= sel_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed vector bench for regfile_wb_arbiter: one table row per clock cycle.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [11:0] req_addr;
  logic [95:0] req_data;
  logic        flush;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        pc_wr_valid;
  logic [31:0] pc_wr_data;
  logic [1:0]  grant_id;

  int total = 0;
  int bad   = 0;

  regfile_wb_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .flush       (flush),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .pc_wr_valid (pc_wr_valid),
    .pc_wr_data  (pc_wr_data),
    .grant_id    (grant_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  v;
    logic [11:0] a;
    logic [95:0] d;
    logic        fl;
    logic        rs;
    logic [2:0]  rdy;
    logic        we;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic        pv;
    logic [31:0] pd;
    logic [1:0]  gid;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [2:0] v, input logic [3:0] a0, a1, a2,
                              input logic [31:0] d0, d1, d2, input logic fl, rs,
                              input logic [2:0] rdy, input logic we, input logic [3:0] wa,
                              input logic [31:0] wd, input logic pv, input logic [31:0] pd,
                              input logic [1:0] gid);
    vec_t r;
    r.v = v; r.a = {a2, a1, a0}; r.d = {d2, d1, d0}; r.fl = fl; r.rs = rs;
    r.rdy = rdy; r.we = we; r.wa = wa; r.wd = wd; r.pv = pv; r.pd = pd; r.gid = gid;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Drive inputs, check ready combinationally, then clock and return.
  task automatic drive(input logic [2:0] v, input logic [11:0] a, input logic [95:0] d,
                       input logic fl, input logic rs, input logic [2:0] rdy, input string tag);
    req_valid = v; req_addr = a; req_data = d; flush = fl; rst = rs;
    #1;
    chk({tag, ".req_ready"}, 32'(req_ready), 32'(rdy));
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t r;
    rst = 1'b1; flush = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
    @(posedge clk); #1;

    //            v      a0 a1 a2   d0            d1            d2           fl rs  rdy    we wa wd            pv pd            gid
    vecs.push_back(mk(3'b111, 0, 0, 0, 32'h0,        32'h0,        32'h0,       0, 1, 3'b000, 0, 0, 32'h0,        0, 32'h0,        0));
    vecs.push_back(mk(3'b000, 0, 0, 0, 32'h0,        32'h0,        32'h0,       0, 0, 3'b000, 0, 0, 32'h0,        0, 32'h0,        0));
    vecs.push_back(mk(3'b000, 0, 0, 0, 32'h0,        32'h0,        32'h0,       0, 0, 3'b000, 0, 0, 32'h0,        0, 32'h0,        0));
    vecs.push_back(mk(3'b010, 0, 5, 0, 32'h0,        32'hDEADBEEF, 32'h0,       0, 0, 3'b010, 1, 5, 32'hDEADBEEF, 0, 32'h0,        1));
    vecs.push_back(mk(3'b000, 0, 5, 0, 32'h0,        32'hDEADBEEF, 32'h0,       0, 0, 3'b000, 0, 5, 32'hDEADBEEF, 0, 32'h0,        1));
    vecs.push_back(mk(3'b111, 1, 2, 3, 32'h11,       32'h22,       32'h33,      0, 0, 3'b001, 1, 1, 32'h11,       0, 32'h0,        0));
    vecs.push_back(mk(3'b110, 1, 2, 3, 32'h11,       32'h22,       32'h33,      0, 0, 3'b010, 1, 2, 32'h22,       0, 32'h0,        1));
    vecs.push_back(mk(3'b100, 1, 2, 3, 32'h11,       32'h22,       32'h33,      0, 0, 3'b100, 1, 3, 32'h33,       0, 32'h0,        2));
    vecs.push_back(mk(3'b001, 15, 0, 0, 32'h2000,    32'h0,        32'h0,       0, 0, 3'b001, 0, 3, 32'h33,       1, 32'h2000,     0));
    vecs.push_back(mk(3'b000, 15, 0, 0, 32'h2000,    32'h0,        32'h0,       0, 0, 3'b000, 0, 3, 32'h33,       0, 32'h2000,     0));
    vecs.push_back(mk(3'b001, 7, 0, 0, 32'h77,       32'h0,        32'h0,       1, 0, 3'b000, 0, 3, 32'h33,       0, 32'h2000,     0));
    vecs.push_back(mk(3'b011, 9, 9, 0, 32'hA,        32'hB,        32'h0,       0, 0, 3'b001, 1, 9, 32'hA,        0, 32'h2000,     0));
    vecs.push_back(mk(3'b010, 9, 9, 0, 32'hA,        32'hB,        32'h0,       0, 0, 3'b010, 1, 9, 32'hB,        0, 32'h2000,     1));
    vecs.push_back(mk(3'b001, 4, 0, 0, 32'h44,       32'h0,        32'h0,       0, 0, 3'b001, 1, 4, 32'h44,       0, 32'h2000,     0));
    vecs.push_back(mk(3'b001, 4, 0, 0, 32'h45,       32'h0,        32'h0,       1, 0, 3'b000, 0, 4, 32'h44,       0, 32'h2000,     0));
    vecs.push_back(mk(3'b001, 6, 0, 0, 32'h66,       32'h0,        32'h0,       0, 0, 3'b001, 1, 6, 32'h66,       0, 32'h2000,     0));
    vecs.push_back(mk(3'b001, 6, 0, 0, 32'h67,       32'h0,        32'h0,       0, 1, 3'b000, 0, 0, 32'h0,        0, 32'h0,        0));
    vecs.push_back(mk(3'b111, 1, 2, 3, 32'h1,        32'h2,        32'h3,       1, 1, 3'b000, 0, 0, 32'h0,        0, 32'h0,        0));

    foreach (vecs[k]) begin
      string tag;
      r = vecs[k];
      tag = $sformatf("row%0d", k);
      drive(r.v, r.a, r.d, r.fl, r.rs, r.rdy, tag);
      chk({tag, ".rf_we"},       32'(rf_we),       32'(r.we));
      chk({tag, ".rf_waddr"},    32'(rf_waddr),    32'(r.wa));
      chk({tag, ".rf_wdata"},    rf_wdata,         r.wd);
      chk({tag, ".pc_wr_valid"}, 32'(pc_wr_valid), 32'(r.pv));
      chk({tag, ".pc_wr_data"},  pc_wr_data,       r.pd);
      chk({tag, ".grant_id"},    32'(grant_id),    32'(r.gid));
    end

    // Starvation: req0 always valid with fresh data, req2 waits 4 cycles then wins.
    for (int c = 0; c < 6; c++) begin
      logic [2:0] v;
      logic [2:0] rdy;
      v   = (c == 5) ? 3'b001 : 3'b101;
      rdy = (c == 4) ? 3'b100 : 3'b001;
      drive(v, {4'd2, 4'd0, 4'd1}, {32'hCC, 32'h0, 32'(100 + c)}, 1'b0, 1'b0, rdy,
            $sformatf("starve%0d", c));
      chk($sformatf("starve%0d.grant_id", c), 32'(grant_id), (c == 4) ? 32'd2 : 32'd0);
      chk($sformatf("starve%0d.rf_waddr", c), 32'(rf_waddr), (c == 4) ? 32'd2 : 32'd1);
      chk($sformatf("starve%0d.rf_wdata", c), rf_wdata, (c == 4) ? 32'hCC : 32'(100 + c));
    end

    // Flush clears ages: 3 losses, flush, then req2 needs 4 more losses to win.
    for (int c = 0; c < 9; c++) begin
      logic fl;
      logic [2:0] rdy;
      fl  = (c == 3);
      rdy = fl ? 3'b000 : ((c == 8) ? 3'b100 : 3'b001);
      drive(3'b101, {4'd3, 4'd0, 4'd8}, {32'hEE, 32'h0, 32'h55}, fl, 1'b0, rdy,
            $sformatf("fage%0d", c));
      chk($sformatf("fage%0d.rf_we", c), 32'(rf_we), fl ? 32'd0 : 32'd1);
    end

    req_valid = '0; flush = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
